// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_controller                                                      |
// | Multi-cycle ARM control FSM: sequences the shared ALU and unified memory,  |
// | holds NZCV flags and gates every state-changing strobe by the condition.   |
// | Optional: define MC_PERF_CNT_EN to add CycleCnt/InstrCnt counters.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rd,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  State
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstrCnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_ex;
  logic [1:0] alu_ctrl;
  logic       no_write;
  logic       alu_arith;
  logic       rd_is_pc;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign rd_is_pc = (Rd == 4'hF);

  // Data-processing command decode from the Funct[4:1] opcode field.
  always_comb begin
    alu_ctrl = 2'b00;
    no_write = 1'b0;
    unique case (Funct[4:1])
      4'b0100: begin alu_ctrl = 2'b00; no_write = 1'b0; end
      4'b0010: begin alu_ctrl = 2'b01; no_write = 1'b0; end
      4'b0000: begin alu_ctrl = 2'b10; no_write = 1'b0; end
      4'b1100: begin alu_ctrl = 2'b11; no_write = 1'b0; end
      4'b1010: begin alu_ctrl = 2'b01; no_write = 1'b1; end
      default: begin alu_ctrl = 2'b00; no_write = 1'b1; end
    endcase
  end

  assign alu_arith = ~alu_ctrl[1];

  // Condition is always judged against the stored flags, never the live ALU output.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ex && Funct[0]) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (alu_arith) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= state_t'(RESET_STATE);
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign State = state_q;

  // Moore decode of the registered state; DECODE reads Op straight from the
  // instruction register, which only settles after the FETCH edge.
  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        RegSrc  = {Op == 2'b01, Op == 2'b10};
        ImmSrc  = (Op == 2'b11) ? 2'b00 : Op;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & rd_is_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      S_EXECR: begin
        ALUControl = alu_ctrl;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctrl;
      end
      S_ALUWB: begin
        RegWrite = cond_ex & ~no_write;
        PCWrite  = cond_ex & rd_is_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_d == S_FETCH) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstrCnt = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_controller                                                   |
// | Directed vector table plus hand sequences for reset abort and counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  State;
`ifdef MC_PERF_CNT_EN
  logic [31:0] CycleCnt, InstrCnt;
`endif

  multicycle_controller #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
`ifdef MC_PERF_CNT_EN
    , .CycleCnt(CycleCnt), .InstrCnt(InstrCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  fl;
    logic [3:0]  st;
    logic [15:0] ctl;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegSrc}
  function automatic logic [15:0] mk(input logic pcw, input logic mw, input logic rw,
                                     input logic irw, input logic adr, input logic [1:0] rs,
                                     input logic sa, input logic [1:0] sb, input logic [1:0] ac,
                                     input logic [1:0] imm, input logic [1:0] rsrc);
    return {pcw, mw, rw, irw, adr, rs, sa, sb, ac, imm, rsrc};
  endfunction

  function automatic logic [15:0] c_fetch();
    return mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_dec(input logic [1:0] op);
    logic [1:0] imm;
    imm = (op == 2'b11) ? 2'b00 : op;
    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, imm, {op == 2'b01, op == 2'b10});
  endfunction
  function automatic logic [15:0] c_execi(input logic [1:0] ac);
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, ac, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_execr(input logic [1:0] ac);
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, ac, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_aluwb(input logic rw, input logic pcw);
    return mk(pcw, 0, rw, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_memadr();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_memrd();
    return mk(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_memwb(input logic rw, input logic pcw);
    return mk(pcw, 0, rw, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_memwr(input logic mw);
    return mk(0, mw, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [15:0] c_branch(input logic pcw);
    return mk(pcw, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b00, 2'b00);
  endfunction

  task automatic add(input logic r, input logic [3:0] c, input logic [1:0] o,
                     input logic [5:0] f, input logic [3:0] d, input logic [3:0] fl,
                     input logic [3:0] s, input logic [15:0] e, input string nm);
    vec_t v;
    v.rst = r; v.cond = c; v.op = o; v.funct = f; v.rd = d; v.fl = fl;
    v.st = s; v.ctl = e; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] d, input logic [3:0] fl);
    Cond = c; Op = o; Funct = f; Rd = d; ALUFlags = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000);

    // ADD R1,R2,#5
    add(1, 4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd0, c_fetch(),        "rst_fetch");
    add(0, 4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd0, c_fetch(),        "add_fetch");
    add(0, 4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd1, c_dec(2'b00),     "add_decode");
    add(0, 4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd7, c_execi(2'b00),   "add_execi");
    add(0, 4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd8, c_aluwb(1, 0),    "add_aluwb");
    // LDR R3,[R4,#8]
    add(0, 4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 4'd0, c_fetch(),        "ldr_fetch");
    add(0, 4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 4'd1, c_dec(2'b01),     "ldr_decode");
    add(0, 4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 4'd2, c_memadr(),       "ldr_memadr");
    add(0, 4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 4'd3, c_memrd(),        "ldr_memrd");
    add(0, 4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 4'd4, c_memwb(1, 0),    "ldr_memwb");
    // CMP R1,R1 with live flags Z=1 -> stored 0100
    add(0, 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 4'd0, c_fetch(),        "cmp_fetch");
    add(0, 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 4'd1, c_dec(2'b00),     "cmp_decode");
    add(0, 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 4'd6, c_execr(2'b01),   "cmp_execr");
    add(0, 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 4'd8, c_aluwb(0, 0),    "cmp_aluwb");
    // BEQ taken (live flags say Z=0 and must be ignored)
    add(0, 4'h0, 2'b10, 6'b100000, 4'd0, 4'b1011, 4'd0, c_fetch(),        "beq_fetch");
    add(0, 4'h0, 2'b10, 6'b100000, 4'd0, 4'b1011, 4'd1, c_dec(2'b10),     "beq_decode");
    add(0, 4'h0, 2'b10, 6'b100000, 4'd0, 4'b1011, 4'd9, c_branch(1),      "beq_branch");
    // BNE not taken
    add(0, 4'h1, 2'b10, 6'b100000, 4'd0, 4'b1011, 4'd0, c_fetch(),        "bne_fetch");
    add(0, 4'h1, 2'b10, 6'b100000, 4'd0, 4'b1011, 4'd1, c_dec(2'b10),     "bne_decode");
    add(0, 4'h1, 2'b10, 6'b100000, 4'd0, 4'b1011, 4'd9, c_branch(0),      "bne_branch");
    // STRNE with Z=1 suppressed
    add(0, 4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000, 4'd0, c_fetch(),        "strne_fetch");
    add(0, 4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000, 4'd1, c_dec(2'b01),     "strne_decode");
    add(0, 4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000, 4'd2, c_memadr(),       "strne_memadr");
    add(0, 4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000, 4'd5, c_memwr(0),       "strne_memwr");
    // ADD PC,... (Rd=15)
    add(0, 4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, 4'd0, c_fetch(),        "movpc_fetch");
    add(0, 4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, 4'd1, c_dec(2'b00),     "movpc_decode");
    add(0, 4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, 4'd6, c_execr(2'b00),   "movpc_execr");
    add(0, 4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, 4'd8, c_aluwb(1, 1),    "movpc_aluwb");
    // ORRS: loads N,Z only -> flags 1000
    add(0, 4'hE, 2'b00, 6'b011001, 4'd1, 4'b1011, 4'd0, c_fetch(),        "orrs_fetch");
    add(0, 4'hE, 2'b00, 6'b011001, 4'd1, 4'b1011, 4'd1, c_dec(2'b00),     "orrs_decode");
    add(0, 4'hE, 2'b00, 6'b011001, 4'd1, 4'b1011, 4'd6, c_execr(2'b11),   "orrs_execr");
    add(0, 4'hE, 2'b00, 6'b011001, 4'd1, 4'b1011, 4'd8, c_aluwb(1, 0),    "orrs_aluwb");
    // BCS not taken (C kept at 0), BMI taken
    add(0, 4'h2, 2'b10, 6'b100000, 4'd0, 4'b0111, 4'd0, c_fetch(),        "bcs_fetch");
    add(0, 4'h2, 2'b10, 6'b100000, 4'd0, 4'b0111, 4'd1, c_dec(2'b10),     "bcs_decode");
    add(0, 4'h2, 2'b10, 6'b100000, 4'd0, 4'b0111, 4'd9, c_branch(0),      "bcs_branch");
    add(0, 4'h4, 2'b10, 6'b100000, 4'd0, 4'b0000, 4'd0, c_fetch(),        "bmi_fetch");
    add(0, 4'h4, 2'b10, 6'b100000, 4'd0, 4'b0000, 4'd1, c_dec(2'b10),     "bmi_decode");
    add(0, 4'h4, 2'b10, 6'b100000, 4'd0, 4'b0000, 4'd9, c_branch(1),      "bmi_branch");
    // Undefined Op=11 returns straight to FETCH
    add(0, 4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 4'd0, c_fetch(),        "und_fetch");
    add(0, 4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 4'd1, c_dec(2'b11),     "und_decode");
    // Cond=1111 never executes
    add(0, 4'hF, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd0, c_fetch(),        "nv_fetch");
    add(0, 4'hF, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd1, c_dec(2'b00),     "nv_decode");
    add(0, 4'hF, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd7, c_execi(2'b00),   "nv_execi");
    add(0, 4'hF, 2'b00, 6'b101000, 4'd1, 4'b0000, 4'd8, c_aluwb(0, 0),    "nv_aluwb");

    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      drive(tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].fl);
      #1;
      chk({tbl[i].name, "_state"}, {28'd0, State}, {28'd0, tbl[i].st});
      chk({tbl[i].name, "_ctl"},
          {16'd0, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc},
          {16'd0, tbl[i].ctl});
      @(negedge clk);
    end

    // Reset during MEMRD aborts the LDR and clears the flags.
    drive(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000);
    #1;
    chk("flags_after_orrs", {28'd0, dut.flags_q}, 32'h8);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_in_memrd", {28'd0, State}, 32'd3);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("abort_state", {28'd0, State}, 32'd0);
      chk("abort_no_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("abort_fetch_strobes", {30'd0, PCWrite, IRWrite}, 32'd3);
    end
    chk("abort_flags_clear", {28'd0, dut.flags_q}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_restart_decode", {28'd0, State}, 32'd1);

`ifdef MC_PERF_CNT_EN
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("perf_cycle_reset", CycleCnt, 32'd0);
    chk("perf_instr_reset", InstrCnt, 32'd0);
    reset = 1'b0;
    drive(4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000);
    repeat (12) @(negedge clk);
    #1;
    chk("perf_cycle_3add", CycleCnt, 32'd12);
    chk("perf_instr_3add", InstrCnt, 32'd3);
    chk("perf_state_fetch", {28'd0, State}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a shared-ALU, unified-memory ARM datapath over several cycles per instruction.
- Replaces the single-cycle decoder. Holds the architectural NZCV flags, evaluates the condition field, and gates every state-changing strobe.
- Sits beside the datapath inside the processor top. Drives mux selects and write enables; receives the latched instruction fields and ALU flags.

Parameters:
- RESET_STATE, 4'd0, FSM encoding entered on reset (FETCH).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- Cond  input  4  Instr[31:28] from the instruction register
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]
- Rd  input  4  Instr[15:12]
- ALUFlags  input  4  live {N,Z,C,V} from the ALU
- PCWrite  output  1  PC register enable
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register-file write enable
- IRWrite  output  1  instruction-register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- ResultSrc  output  2  00 ALUOut reg, 01 Data reg, 10 ALUResult (live)
- ALUSrcA  output  1  0 = register A, 1 = PC
- ALUSrcB  output  2  00 reg B/shifted, 01 ExtImm, 10 constant 4
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  output  2  00 imm8, 01 imm12, 10 branch imm24
- RegSrc  output  2  [0] RA1 = R15, [1] RA2 = Rd
- State  output  4  current FSM state, for debug

Behaviour:
- States:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH.
  - Unused encodings go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECR; with Funct[5]=1 -> EXECI.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH (undefined instruction, treated as NOP).
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH -> FETCH.
- Reset: State=FETCH and flags=0000 on the next edge. All outputs are Moore, decoded from State plus gating. During reset the outputs show the FETCH decode, but the datapath PC is held in reset. Reset in any state aborts the instruction with no further strobes.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 unconditionally.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, so ALUOut = PC+8.
  - RegSrc={Op==01, Op==10}.
  - ImmSrc = Op for Op<11, else 00.
- ALU decode (EXECR/EXECI):
  - Cmd = Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB with NoWrite).
  - Any other Cmd behaves as ADD with NoWrite=1.
  - In MEMADR and BRANCH, ALUControl=ADD; Funct[3] (U bit) is ignored.
- Condition check:
  - CondEx is evaluated from the stored flags, never the live ALUFlags.
  - Codes 0000-1110 follow standard ARM (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL).
  - 1111 -> CondEx=0.
- Flag update, at the end of EXECR/EXECI only, when CondEx=1 and Funct[0]=1:
  - N,Z always load from ALUFlags[3:2].
  - C,V load from ALUFlags[1:0] only for ADD/SUB/CMP.
  - Flags are evaluated for CondEx before the update, in the same cycle (old flags).
- Gating:
  - RegWrite is asserted in MEMWB and ALUWB only if CondEx=1. In ALUWB it additionally requires NoWrite=0.
  - MemWrite is asserted in MEMWR only if CondEx=1.
  - PCWrite is asserted in BRANCH if CondEx=1. In ALUWB and MEMWB it is asserted if CondEx=1 and Rd=1111; Result then drives the PC.
- Write-back: MEMWB uses ResultSrc=01, ALUWB uses ResultSrc=00.
- All other outputs default to 0 in every state.
- Latency: branch 3 cycles, data-processing 4, STR 4, LDR 5.

Optional Feature:
- MC_PERF_CNT_EN: adds two outputs, CycleCnt[31:0] and InstrCnt[31:0].
  - CycleCnt increments every non-reset cycle.
  - InstrCnt increments on entry to FETCH from any non-reset state.
  - Both clear on reset and wrap 0xFFFFFFFF -> 0.
- Without the macro: neither port nor the counters exist.

Test Plan:
- Reset held 2 cycles, released -> State=0, PCWrite=1, IRWrite=1, AdrSrc=0, flags=0000.
- ADD R1,R2,#5 (Funct=101000, Cond=1110) -> states 0,1,7,8,0. ALUSrcB=01 in EXECI. RegWrite=1 only in ALUWB. PCWrite=0 in ALUWB.
- LDR R3,[R4,#8] -> states 0,1,2,3,4,0. AdrSrc=1 in MEMRD. ResultSrc=01 with RegWrite=1 in MEMWB.
- CMP R1,R1 (S=1), ALUFlags=0100, then BEQ -> flags=0100; BRANCH asserts PCWrite=1. Then BNE -> 0,1,9,0 with PCWrite=0 in BRANCH.
- STRNE with Z=1 -> MEMWR has MemWrite=0. MOV PC via ADD Rd=1111 with AL -> ALUWB asserts PCWrite=1 and RegWrite=1.
- Reset asserted during MEMRD -> next state FETCH, no RegWrite pulse. With MC_PERF_CNT_EN: after 3 ADDs, InstrCnt=3 and CycleCnt=12.
